// File: rtl/scalar_wb_arbiter_if.sv
// Writeback arbiter bus: FU completions in, regfile/dispatch write out.
// slave is the arbiter side, master the execute/regfile side.
interface scalar_wb_arbiter_if #(
    parameter int DEPTH  = 8,
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              alu_done;
    logic [WORD_W-1:0] alu_wdat;
    logic [REG_W-1:0]  alu_reg_sel;
    logic              load_done;
    logic [WORD_W-1:0] load_wdat;
    logic [REG_W-1:0]  load_reg_sel;
    logic              jump_done;
    logic [WORD_W-1:0] jump_wdat;
    logic [REG_W-1:0]  jump_reg_sel;
    logic              ex_spec;
    logic              bfu_resolved;
    logic              bfu_miss;
    logic              wb_ready;
    logic              wb_reg_en;
    logic [REG_W-1:0]  wb_reg_sel;
    logic [WORD_W-1:0] wb_wdat;
    logic              s_rw_en;
    logic [REG_W-1:0]  s_rw;
    logic [CNT_W-1:0]  wb_count;
    logic              wb_overflow;

    modport slave (
        input  alu_done, alu_wdat, alu_reg_sel,
        input  load_done, load_wdat, load_reg_sel,
        input  jump_done, jump_wdat, jump_reg_sel,
        input  ex_spec, bfu_resolved, bfu_miss,
        output wb_ready, wb_reg_en, wb_reg_sel, wb_wdat,
        output s_rw_en, s_rw, wb_count, wb_overflow
    );

    modport master (
        output alu_done, alu_wdat, alu_reg_sel,
        output load_done, load_wdat, load_reg_sel,
        output jump_done, jump_wdat, jump_reg_sel,
        output ex_spec, bfu_resolved, bfu_miss,
        input  wb_ready, wb_reg_en, wb_reg_sel, wb_wdat,
        input  s_rw_en, s_rw, wb_count, wb_overflow
    );
endinterface

// File: rtl/scalar_wb_arbiter.sv
// Scalar writeback arbiter: FIFO of FU results, one regfile write per
// cycle, speculative entries held until branch resolve, squashed on miss.
module scalar_wb_arbiter #(
    parameter int DEPTH  = 8,
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input logic               CLK,
    input logic               nRST,
    scalar_wb_arbiter_if.slave wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  e_valid;
    logic [DEPTH-1:0]  e_spec;
    logic [REG_W-1:0]  e_sel [DEPTH];
    logic [WORD_W-1:0] e_dat [DEPTH];

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [CW-1:0]     free;
    logic              ovf;

    logic [2:0]        req;
    logic [2:0]        take;
    logic [REG_W-1:0]  rsel [3];
    logic [WORD_W-1:0] rdat [3];
    logic [PW-1:0]     widx [3];
    logic [CW-1:0]     n_enq;
    logic              drop;
    logic              new_spec;

    logic              pop;
    logic              w_en;
    logic [REG_W-1:0]  w_sel;
    logic [WORD_W-1:0] w_dat;

    // Enqueue in load, alu, jump order; slots limited by registered count.
    always_comb begin
        rsel[0] = wb.load_reg_sel;
        rdat[0] = wb.load_wdat;
        rsel[1] = wb.alu_reg_sel;
        rdat[1] = wb.alu_wdat;
        rsel[2] = wb.jump_reg_sel;
        rdat[2] = wb.jump_wdat;
        req[0]  = wb.load_done;
        req[1]  = wb.alu_done;
        req[2]  = wb.jump_done;
        free     = CW'(DEPTH) - count;
        new_spec = wb.ex_spec && !wb.bfu_resolved;
        n_enq    = '0;
        drop     = 1'b0;
        take     = '0;
        for (int i = 0; i < 3; i++) begin
            widx[i] = tail + PW'(n_enq);
            if (req[i] && rsel[i] != '0 &&
                !(wb.bfu_miss && wb.ex_spec)) begin
                if (n_enq < free) begin
                    take[i] = 1'b1;
                    n_enq   = n_enq + CW'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pop   = 1'b0;
        w_en  = 1'b0;
        w_sel = '0;
        w_dat = '0;
        if (count != '0) begin
            if (!e_valid[head]) begin
                pop = 1'b1;
            end else if (!e_spec[head]) begin
                pop   = 1'b1;
                w_en  = 1'b1;
                w_sel = e_sel[head];
                w_dat = e_dat[head];
            end
        end
    end

    assign wb.wb_ready    = free >= CW'(3);
    assign wb.wb_reg_en   = w_en;
    assign wb.wb_reg_sel  = w_sel;
    assign wb.wb_wdat     = w_dat;
    assign wb.s_rw_en     = w_en;
    assign wb.s_rw        = w_sel;
    assign wb.wb_count    = count;
    assign wb.wb_overflow = ovf;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            e_valid <= '0;
            e_spec  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_sel[i] <= '0;
                e_dat[i] <= '0;
            end
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(n_enq);
            count <= count - CW'(pop) + n_enq;
            if (drop) ovf <= 1'b1;
            // Miss dominates resolve; squashed entries drain as invalid.
            for (int i = 0; i < DEPTH; i++) begin
                if (wb.bfu_miss) begin
                    if (e_spec[i]) e_valid[i] <= 1'b0;
                    e_spec[i] <= 1'b0;
                end else if (wb.bfu_resolved) begin
                    e_spec[i] <= 1'b0;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (take[k]) begin
                    e_valid[widx[k]] <= 1'b1;
                    e_spec[widx[k]]  <= new_spec;
                    e_sel[widx[k]]   <= rsel[k];
                    e_dat[widx[k]]   <= rdat[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed self-checking bench for scalar_wb_arbiter.
// Inputs change #1 after the rising edge; outputs sampled there too.
module tb_scalar_wb_arbiter;
    localparam int DEPTH  = 8;
    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    logic CLK;
    logic nRST;
    int   n_chk;
    int   n_fail;

    scalar_wb_arbiter_if #(
        .DEPTH(DEPTH), .WORD_W(WORD_W), .REG_W(REG_W)
    ) w ();

    scalar_wb_arbiter #(
        .DEPTH(DEPTH), .WORD_W(WORD_W), .REG_W(REG_W)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .wb  (w)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        w.alu_done     = 1'b0;
        w.alu_wdat     = '0;
        w.alu_reg_sel  = '0;
        w.load_done    = 1'b0;
        w.load_wdat    = '0;
        w.load_reg_sel = '0;
        w.jump_done    = 1'b0;
        w.jump_wdat    = '0;
        w.jump_reg_sel = '0;
        w.ex_spec      = 1'b0;
        w.bfu_resolved = 1'b0;
        w.bfu_miss     = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic put3(input logic [4:0] l, input logic [4:0] a,
                        input logic [4:0] j, input logic sp);
        w.load_done    = (l != 0);
        w.load_reg_sel = l;
        w.load_wdat    = 32'h100 + 32'(l);
        w.alu_done     = (a != 0);
        w.alu_reg_sel  = a;
        w.alu_wdat     = 32'h100 + 32'(a);
        w.jump_done    = (j != 0);
        w.jump_reg_sel = j;
        w.jump_wdat    = 32'h100 + 32'(j);
        w.ex_spec      = sp;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        nRST   = 1'b0;
        clr();
        step();
        step();
        chk("rst_ready", w.wb_ready, 1);
        chk("rst_en", w.wb_reg_en, 0);
        chk("rst_sel", w.wb_reg_sel, 0);
        chk("rst_wdat", w.wb_wdat, 0);
        chk("rst_cnt", w.wb_count, 0);
        chk("rst_ovf", w.wb_overflow, 0);
        nRST = 1'b1;
        step();

        // single non-spec ALU result
        w.alu_done = 1'b1;
        w.alu_reg_sel = 5;
        w.alu_wdat = 32'hDEAD_BEEF;
        chk("t1_nobypass", w.wb_reg_en, 0);
        step();
        clr();
        chk("t1_en", w.wb_reg_en, 1);
        chk("t1_sel", w.wb_reg_sel, 5);
        chk("t1_srw", w.s_rw, 5);
        chk("t1_srwen", w.s_rw_en, 1);
        chk("t1_wdat", w.wb_wdat, 64'hDEAD_BEEF);
        chk("t1_cnt", w.wb_count, 1);
        step();
        chk("t1_idle", w.wb_reg_en, 0);
        chk("t1_cnt0", w.wb_count, 0);
        chk("t1_idle_wdat", w.wb_wdat, 0);

        // three results in one cycle: load, alu, jump order
        put3(3, 4, 1, 0);
        step();
        clr();
        chk("t2_cnt3", w.wb_count, 3);
        chk("t2_sel3", w.wb_reg_sel, 3);
        chk("t2_dat3", w.wb_wdat, 32'h103);
        step();
        chk("t2_cnt2", w.wb_count, 2);
        chk("t2_sel4", w.wb_reg_sel, 4);
        step();
        chk("t2_cnt1", w.wb_count, 1);
        chk("t2_sel1", w.wb_reg_sel, 1);
        chk("t2_dat1", w.wb_wdat, 32'h101);
        step();
        chk("t2_cnt0", w.wb_count, 0);
        chk("t2_en0", w.wb_reg_en, 0);

        // x0 destination never allocates
        w.alu_done = 1'b1;
        w.alu_reg_sel = 0;
        w.load_done = 1'b1;
        w.load_reg_sel = 7;
        w.load_wdat = 32'h77;
        step();
        clr();
        chk("t3_cnt1", w.wb_count, 1);
        chk("t3_sel7", w.wb_reg_sel, 7);
        step();
        chk("t3_cnt0", w.wb_count, 0);
        chk("t3_en0", w.wb_reg_en, 0);

        // speculative result held until resolve
        put3(0, 9, 0, 1);
        step();
        clr();
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold", w.wb_reg_en, 0);
            if (i < 4) step();
        end
        chk("t4_cnt", w.wb_count, 1);
        w.bfu_resolved = 1'b1;
        step();
        clr();
        chk("t4_en", w.wb_reg_en, 1);
        chk("t4_sel9", w.wb_reg_sel, 9);
        step();
        chk("t4_cnt0", w.wb_count, 0);

        // mispredict squashes spec entries and this-cycle spec results
        put3(2, 0, 0, 0);
        step();
        clr();
        chk("t5_sel2", w.wb_reg_sel, 2);
        chk("t5_en2", w.wb_reg_en, 1);
        put3(0, 6, 8, 1);
        step();
        clr();
        chk("t5_cnt2", w.wb_count, 2);
        chk("t5_held", w.wb_reg_en, 0);
        w.bfu_miss = 1'b1;
        put3(0, 10, 0, 1);
        w.bfu_miss = 1'b1;
        step();
        clr();
        chk("t5_miss_cnt", w.wb_count, 2);
        chk("t5_miss_en", w.wb_reg_en, 0);
        step();
        chk("t5_drain1", w.wb_count, 1);
        chk("t5_drain_en", w.wb_reg_en, 0);
        step();
        chk("t5_drain0", w.wb_count, 0);
        chk("t5_end_en", w.wb_reg_en, 0);

        // fill, overflow, push at full, async reset mid-drain
        put3(20, 21, 22, 1);
        step();
        chk("t6_ready3", w.wb_ready, 1);
        put3(23, 24, 25, 1);
        step();
        clr();
        chk("t6_cnt6", w.wb_count, 6);
        chk("t6_ready0", w.wb_ready, 0);
        put3(11, 12, 13, 1);
        step();
        clr();
        chk("t6_cnt8", w.wb_count, 8);
        chk("t6_ovf", w.wb_overflow, 1);
        w.bfu_resolved = 1'b1;
        step();
        clr();
        chk("t6_res_cnt", w.wb_count, 8);
        chk("t6_res_sel", w.wb_reg_sel, 20);
        put3(0, 14, 0, 0);
        step();
        clr();
        chk("t6_full_cnt", w.wb_count, 7);
        chk("t6_full_sel", w.wb_reg_sel, 21);
        step();
        chk("t6_cnt6b", w.wb_count, 6);
        chk("t6_sel22", w.wb_reg_sel, 22);
        chk("t6_ovf_sticky", w.wb_overflow, 1);
        #2;
        nRST = 1'b0;
        #1;
        chk("t6_rst_cnt", w.wb_count, 0);
        chk("t6_rst_en", w.wb_reg_en, 0);
        chk("t6_rst_sel", w.wb_reg_sel, 0);
        chk("t6_rst_ovf", w.wb_overflow, 0);
        chk("t6_rst_ready", w.wb_ready, 1);
        step();
        nRST = 1'b1;
        step();
        chk("t6_post_cnt", w.wb_count, 0);
        chk("t6_post_en", w.wb_reg_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
